// File: rtl/kd_tree_sequencer.sv
// kd_tree_sequencer: drives a kd-tree root node through reset, center fill and sorting, with a per-state handshake timeout.
module kd_tree_sequencer #(
  parameter int COMMAND_SIZE = 5,
  parameter int DATA_SIZE = 24,
  parameter int NUM_CENTERS = 10,
  parameter int ADDR_W = 4,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic [ADDR_W-1:0] center_addr,
  input  logic [DATA_SIZE-1:0] center_rdata,
  output logic [COMMAND_SIZE-1:0] command_to_root,
  output logic [DATA_SIZE-1:0] data_to_root,
  input  logic [COMMAND_SIZE-1:0] command_from_root,
  output logic busy,
  output logic done,
  output logic error,
  output logic [CNT_W-1:0] cycle_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = ADDR_W + 1;
  localparam logic [COMMAND_SIZE-1:0] C_NOP = COMMAND_SIZE'(5'h00);
  localparam logic [COMMAND_SIZE-1:0] C_FILL = COMMAND_SIZE'(5'h01);
  localparam logic [COMMAND_SIZE-1:0] C_FILL_DONE = COMMAND_SIZE'(5'h05);
  localparam logic [COMMAND_SIZE-1:0] C_SORT = COMMAND_SIZE'(5'h09);
  localparam logic [COMMAND_SIZE-1:0] C_DNE = COMMAND_SIZE'(5'h10);
  localparam logic [COMMAND_SIZE-1:0] C_RST_DONE = COMMAND_SIZE'(5'h1e);
  localparam logic [COMMAND_SIZE-1:0] C_RST = COMMAND_SIZE'(5'h1f);
  typedef enum logic [2:0] {IDLE, RST, FILL, SORT, WAIT_SORT, DONE, ERR} state_t;
  state_t state, state_n;
  logic [COMMAND_SIZE-1:0] cmd_n;
  logic [DATA_SIZE-1:0] data_n;
  logic [ADDR_W-1:0] addr_n;
  logic [SW-1:0] sent, sent_n;
  logic [TW-1:0] timer, timer_n;
  logic [CNT_W-1:0] cc_n;
  logic tmo;
  assign busy = state == RST || state == FILL || state == SORT || state == WAIT_SORT;
  assign done = state == DONE;
  assign error = state == ERR;
  assign tmo = timer == TW'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    cmd_n = C_NOP;
    data_n = '0;
    addr_n = center_addr;
    sent_n = sent;
    timer_n = timer;
    cc_n = (busy && cycle_count != '1) ? cycle_count + 1'b1 : cycle_count;
    case (state)
      IDLE, DONE, ERR: if (start) begin
        state_n = RST;
        cmd_n = C_RST;
        cc_n = '0;
        timer_n = '0;
      end
      RST: begin
        timer_n = timer + 1'b1;
        cmd_n = C_RST;
        if (command_from_root == C_RST_DONE) begin
          state_n = FILL;
          cmd_n = C_NOP;
          addr_n = '0;
          sent_n = '0;
          timer_n = '0;
        end else if (tmo) begin
          state_n = ERR;
          cmd_n = C_NOP;
        end
      end
      FILL: if (command_from_root == C_FILL_DONE) begin
        state_n = SORT;
        cmd_n = C_SORT;
      end else if (sent < SW'(NUM_CENTERS)) begin
        cmd_n = C_FILL;
        data_n = center_rdata;
        addr_n = center_addr + 1'b1;
        sent_n = sent + 1'b1;
      end else begin
        timer_n = timer + 1'b1;
        state_n = tmo ? ERR : FILL;
      end
      SORT: begin
        state_n = WAIT_SORT;
        timer_n = '0;
      end
      WAIT_SORT: begin
        timer_n = timer + 1'b1;
        state_n = (command_from_root == C_DNE) ? DONE : tmo ? ERR : WAIT_SORT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      command_to_root <= C_NOP;
      data_to_root <= '0;
      center_addr <= '0;
      sent <= '0;
      timer <= '0;
      cycle_count <= '0;
    end else begin
      state <= state_n;
      command_to_root <= cmd_n;
      data_to_root <= data_n;
      center_addr <= addr_n;
      sent <= sent_n;
      timer <= timer_n;
      cycle_count <= cc_n;
    end
  end
endmodule

// File: doc/kd_tree_sequencer.md
KD_TREE_SEQUENCER -- requirements
Module: kd_tree_sequencer

Interface
REQ-001 Parameters (name, default, meaning): COMMAND_SIZE, 5, node command width; DATA_SIZE, 24, node data/pixel width; NUM_CENTERS, 10, centers loaded per run; ADDR_W, 4, center memory address width; TIMEOUT, 1023, max wait cycles per handshake state; CNT_W, 27, run cycle counter width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle run request; sampled in IDLE, DONE, ERR only.
REQ-005 center_addr  out  ADDR_W  center memory read address (registered).
REQ-006 center_rdata  in  DATA_SIZE  mem[center_addr], valid in the same cycle (asynchronous read).
REQ-007 command_to_root  out  COMMAND_SIZE  command to root node command_from_top (registered).
REQ-008 data_to_root  out  DATA_SIZE  data to root node data_from_top (registered).
REQ-009 command_from_root  in  COMMAND_SIZE  root node command_to_top.
REQ-010 busy  out  1  high in RST, FILL, SORT, WAIT_SORT.
REQ-011 done  out  1  high in DONE.
REQ-012 error  out  1  high in ERR.
REQ-013 cycle_count  out  CNT_W  cycles elapsed in current/last run.

Function
REQ-014 Command codes: nop 5'h00, center_fill 5'h01, center_fill_done 5'h05, start_sorting 5'h09, dne 5'h10, rst_done 5'h1e, rst 5'h1f; all others from root are ignored.
REQ-015 States: IDLE, RST, FILL, SORT, WAIT_SORT, DONE, ERR; state and all outputs change only on the rising edge.
REQ-016 IDLE: command nop, data 0; start=1 -> RST, cycle_count<=0, command_to_root<=rst on that same edge.
REQ-017 RST: command rst each cycle; command_from_root==rst_done -> FILL, center_addr<=0, sent<=0, command nop.
REQ-018 FILL, sent<NUM_CENTERS: each edge data_to_root<=center_rdata, command<=center_fill, center_addr<=center_addr+1, sent<=sent+1; one word per cycle, no gaps.
REQ-019 FILL, sent==NUM_CENTERS: command nop, data 0, center_addr holds; wait for center_fill_done.
REQ-020 center_fill_done in FILL at any sent count -> SORT immediately; no further center_fill issued.
REQ-021 SORT: exactly one cycle of start_sorting with data 0, then -> WAIT_SORT.
REQ-022 WAIT_SORT: command nop; command_from_root==dne -> DONE.
REQ-023 Timeout: per-state timer cleared on entry to RST, FILL, WAIT_SORT; counts every cycle in RST, in WAIT_SORT, and in FILL only once sent==NUM_CENTERS; reaching TIMEOUT without the expected response -> ERR, command nop.
REQ-024 Expected response and timeout on the same edge: response wins.
REQ-025 DONE and ERR hold outputs (done/error=1, command nop) until start=1 (-> RST, new run) or reset.
REQ-026 start while busy is ignored; no queuing.
REQ-027 cycle_count increments every busy cycle, saturates at all-ones, freezes in DONE/ERR, cleared on run start.
REQ-028 sent and center_addr never exceed NUM_CENTERS; NUM_CENTERS<=2**ADDR_W.

Reset
REQ-029 reset=1 at any edge, in any state including mid-FILL: state<=IDLE; command_to_root<=nop; data_to_root<=0; center_addr<=0; busy, done, error<=0; cycle_count<=0; timer, sent<=0.
REQ-030 reset has priority over start and all root responses in the same cycle.

Verification
REQ-031 Normal run: start; root answers rst_done after 3 cycles, center_fill_done 2 cycles after 10th word, dne 20 cycles after start_sorting -> 10 center_fill words mem[0..9] in consecutive cycles, one start_sorting cycle, done=1, cycle_count=38.
REQ-032 Early fill done: center_fill_done asserted after 4th word -> exactly 4 center_fill words, next command start_sorting.
REQ-033 Timeout: root never answers rst_done -> rst driven 1023 cycles, then error=1, command nop; subsequent start restarts in RST.
REQ-034 Reset mid-FILL after 5th word -> next cycle IDLE, command nop, center_addr 0, busy 0; new start reloads from address 0.
REQ-035 start pulses during WAIT_SORT and same-cycle dne+timeout -> starts ignored; DONE entered, error stays 0.
